// File: rtl/mag_sar.sv
// Successive-approximation search engine.
// Drives the reference side of an external unsigned magnitude comparator and
// recovers the unknown compared value one bit per cycle, MSB first.
module mag_sar #(
  parameter int WIDTH = 8,
  parameter bit EARLY = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_vld,
  output logic             req_rdy,
  output logic [WIDTH-1:0] rfr,
  input  logic             grt,
  input  logic             lst,
  output logic             rsp_vld,
  input  logic             rsp_rdy,
  output logic [WIDTH-1:0] rsp_dat,
  output logic             rsp_err
);

  localparam int            IW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SRCH = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] rsp_dat_q, rsp_dat_d;
  logic             rsp_err_q, rsp_err_d;
  logic             req_rdy_q, req_rdy_d;
  logic             rsp_vld_q, rsp_vld_d;
  logic [WIDTH-1:0] trial;

  // Candidate reference for the current trial: bits already decided plus the
  // bit under test forced to one.
  function automatic logic [WIDTH-1:0] trial_ref(input logic [WIDTH-1:0] acc,
                                                 input logic [IW-1:0]    idx);
    logic [WIDTH-1:0] mask;
    mask      = '0;
    mask[idx] = 1'b1;
    return acc | mask;
  endfunction

  // Next-state, accumulator update and reference selection for each state.
  always_comb begin
    trial     = trial_ref(acc_q, idx_q);
    state_d   = state_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    rsp_dat_d = rsp_dat_q;
    rsp_err_d = rsp_err_q;
    rfr       = '0;

    unique case (state_q)
      IDLE: begin
        if (req_vld) begin
          state_d   = SRCH;
          acc_d     = '0;
          idx_d     = IDX_TOP;
          rsp_err_d = 1'b0;
        end
      end
      SRCH: begin
        rfr = trial;
        if (grt && lst) begin
          // Inconsistent comparator: report only the bits decided before this trial.
          state_d   = DONE;
          rsp_err_d = 1'b1;
          rsp_dat_d = acc_q;
        end else begin
          // val >= trial means the tested bit belongs to the answer.
          if (!lst) begin
            acc_d = trial;
          end
          if (EARLY && !grt && !lst) begin
            state_d   = DONE;
            rsp_dat_d = trial;
          end else if (idx_q == '0) begin
            state_d   = DONE;
            rsp_dat_d = acc_d;
          end else begin
            idx_d = idx_q - IW'(1);
          end
        end
      end
      DONE: begin
        rfr = rsp_dat_q;
        if (rsp_rdy) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    req_rdy_d = (state_d == IDLE);
    rsp_vld_d = (state_d == DONE);
  end

  // State and datapath registers; reset aborts any search in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      idx_q     <= IDX_TOP;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
      req_rdy_q <= 1'b1;
      rsp_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_err_q <= rsp_err_d;
      req_rdy_q <= req_rdy_d;
      rsp_vld_q <= rsp_vld_d;
    end
  end

  assign req_rdy = req_rdy_q;
  assign rsp_vld = rsp_vld_q;
  assign rsp_dat = rsp_dat_q;
  assign rsp_err = rsp_err_q;

endmodule

// File: tb/tb_mag_sar.sv
// Testbench for mag_sar: one instance with EARLY=0 and one with EARLY=1,
// each closed through a behavioural comparator that can be forced to report
// grt and lst together at a chosen reference value.
module tb_mag_sar;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic         sel;
  logic         req_vld_s, rsp_rdy_s;
  logic [W-1:0] val_s, inj_rfr;
  logic         inj_en;

  logic         req_rdy0, grt0, lst0, rsp_vld0, rsp_err0;
  logic [W-1:0] rfr0, rsp_dat0;
  logic         req_rdy1, grt1, lst1, rsp_vld1, rsp_err1;
  logic [W-1:0] rfr1, rsp_dat1;

  assign grt0 = (val_s > rfr0) || (inj_en && rfr0 == inj_rfr);
  assign lst0 = (val_s < rfr0) || (inj_en && rfr0 == inj_rfr);
  assign grt1 = (val_s > rfr1) || (inj_en && rfr1 == inj_rfr);
  assign lst1 = (val_s < rfr1) || (inj_en && rfr1 == inj_rfr);

  logic         req_rdy_s, rsp_vld_s, rsp_err_s;
  logic [W-1:0] rfr_s, rsp_dat_s;
  assign req_rdy_s = sel ? req_rdy1 : req_rdy0;
  assign rsp_vld_s = sel ? rsp_vld1 : rsp_vld0;
  assign rsp_err_s = sel ? rsp_err1 : rsp_err0;
  assign rfr_s     = sel ? rfr1     : rfr0;
  assign rsp_dat_s = sel ? rsp_dat1 : rsp_dat0;

  mag_sar #(.WIDTH(W), .EARLY(1'b0)) dut0 (
    .clk(clk), .rst(rst),
    .req_vld(req_vld_s && !sel), .req_rdy(req_rdy0),
    .rfr(rfr0), .grt(grt0), .lst(lst0),
    .rsp_vld(rsp_vld0), .rsp_rdy(rsp_rdy_s && !sel),
    .rsp_dat(rsp_dat0), .rsp_err(rsp_err0)
  );

  mag_sar #(.WIDTH(W), .EARLY(1'b1)) dut1 (
    .clk(clk), .rst(rst),
    .req_vld(req_vld_s && sel), .req_rdy(req_rdy1),
    .rfr(rfr1), .grt(grt1), .lst(lst1),
    .rsp_vld(rsp_vld1), .rsp_rdy(rsp_rdy_s && sel),
    .rsp_dat(rsp_dat1), .rsp_err(rsp_err1)
  );

  // Binary-search reference for trial t (0-based): the top t bits of val,
  // followed by a one at the bit under test.
  function automatic int rfr_at(input int v, input int t);
    return ((v >> (W - t)) << (W - t)) | (1 << (W - 1 - t));
  endfunction

  // One complete request/response transaction with per-cycle checks.
  // Entered and left just after a falling edge.
  task automatic run_search(input int v, input bit early, input int inj_j, input int stall);
    int           n_nat, n, tz;
    logic [W-1:0] exp_dat, exp_rfr;
    logic         exp_err;
    n_nat = W;
    if (early && v != 0) begin
      tz = 0;
      while (((v >> tz) & 1) == 0) tz++;
      n_nat = W - tz;
    end
    if (inj_j >= 0 && inj_j < n_nat) begin
      n       = inj_j + 1;
      exp_dat = W'((v >> (W - inj_j)) << (W - inj_j));
      exp_err = 1'b1;
    end else begin
      n       = n_nat;
      exp_dat = W'(v);
      exp_err = 1'b0;
    end

    sel       = early;
    val_s     = W'(v);
    inj_en    = (inj_j >= 0);
    inj_rfr   = (inj_j >= 0) ? W'(rfr_at(v, inj_j)) : '0;
    req_vld_s = 1'b1;
    rsp_rdy_s = 1'b0;
    checks++;
    if (req_rdy_s !== 1'b1) begin
      errors++;
      $display("FAIL start_rdy val=%h got %b exp 1", v[W-1:0], req_rdy_s);
    end
    @(posedge clk); @(negedge clk);

    for (int t = 0; t < n; t++) begin
      exp_rfr   = W'(rfr_at(v, t));
      req_vld_s = 1'($urandom % 2);
      checks++;
      if ({rfr_s, rsp_vld_s, req_rdy_s} !== {exp_rfr, 2'b00}) begin
        errors++;
        $display("FAIL trial%0d val=%h rfr/vld/rdy got %h/%b/%b exp %h/0/0",
                 t, v[W-1:0], rfr_s, rsp_vld_s, req_rdy_s, exp_rfr);
      end
      @(posedge clk); @(negedge clk);
    end

    for (int s = 0; s <= stall; s++) begin
      rsp_rdy_s = (s == stall);
      req_vld_s = 1'($urandom % 2);
      checks++;
      if ({rsp_vld_s, rsp_dat_s, rsp_err_s, rfr_s, req_rdy_s} !==
          {1'b1, exp_dat, exp_err, exp_dat, 1'b0}) begin
        errors++;
        $display("FAIL done%0d val=%h vld/dat/err/rfr/rdy got %b/%h/%b/%h/%b exp 1/%h/%b/%h/0",
                 s, v[W-1:0], rsp_vld_s, rsp_dat_s, rsp_err_s, rfr_s, req_rdy_s,
                 exp_dat, exp_err, exp_dat);
      end
      @(posedge clk); @(negedge clk);
    end

    rsp_rdy_s = 1'b0;
    req_vld_s = 1'b0;
    inj_en    = 1'b0;
    checks++;
    if ({rsp_vld_s, req_rdy_s, rfr_s} !== {1'b0, 1'b1, {W{1'b0}}}) begin
      errors++;
      $display("FAIL after_hs val=%h vld/rdy/rfr got %b/%b/%h exp 0/1/00",
               v[W-1:0], rsp_vld_s, req_rdy_s, rfr_s);
    end
  endtask

  task automatic test_reset();
    sel = 1'b0; req_vld_s = 1'b0; rsp_rdy_s = 1'b0;
    val_s = '0; inj_en = 1'b0; inj_rfr = '0;
    rst = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    checks++;
    if ({req_rdy0, rsp_vld0, rsp_dat0, rsp_err0, rfr0} !== {1'b1, 1'b0, {W{1'b0}}, 1'b0, {W{1'b0}}}) begin
      errors++;
      $display("FAIL reset0 rdy/vld/dat/err/rfr got %b/%b/%h/%b/%h exp 1/0/00/0/00",
               req_rdy0, rsp_vld0, rsp_dat0, rsp_err0, rfr0);
    end
    checks++;
    if ({req_rdy1, rsp_vld1, rsp_dat1, rsp_err1, rfr1} !== {1'b1, 1'b0, {W{1'b0}}, 1'b0, {W{1'b0}}}) begin
      errors++;
      $display("FAIL reset1 rdy/vld/dat/err/rfr got %b/%b/%h/%b/%h exp 1/0/00/0/00",
               req_rdy1, rsp_vld1, rsp_dat1, rsp_err1, rfr1);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    run_search(8'hA5, 1'b0, -1, 0);
    run_search(8'h00, 1'b0, -1, 0);
    run_search(8'hFF, 1'b0, -1, 0);
  endtask

  task automatic test_early();
    run_search(8'h80, 1'b1, -1, 0);
    run_search(8'h01, 1'b1, -1, 0);
    run_search(8'h00, 1'b1, -1, 0);
    run_search(8'h10, 1'b1, -1, 1);
  endtask

  task automatic test_error();
    run_search(8'hA5, 1'b0, 3, 0);
    run_search(8'hA5, 1'b0, 0, 0);
    run_search(8'h3C, 1'b1, 2, 1);
    run_search(8'h5A, 1'b0, -1, 0);
  endtask

  task automatic test_stall();
    run_search(int'($urandom_range(0, 255)), 1'b0, -1, 5);
    run_search(int'($urandom_range(0, 255)), 1'b1, -1, 5);
  endtask

  task automatic test_reset_abort();
    int v;
    v         = 8'hA5;
    sel       = 1'b0;
    val_s     = W'(v);
    req_vld_s = 1'b1;
    @(posedge clk); @(negedge clk);
    req_vld_s = 1'b0;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
    end
    checks++;
    if (rfr_s !== W'(rfr_at(v, 3))) begin
      errors++;
      $display("FAIL abort_trial4 rfr got %h exp %h", rfr_s, W'(rfr_at(v, 3)));
    end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({rsp_vld_s, req_rdy_s, rfr_s, rsp_dat_s, rsp_err_s} !== {1'b0, 1'b1, {W{1'b0}}, {W{1'b0}}, 1'b0}) begin
      errors++;
      $display("FAIL abort_idle vld/rdy/rfr/dat/err got %b/%b/%h/%h/%b exp 0/1/00/00/0",
               rsp_vld_s, req_rdy_s, rfr_s, rsp_dat_s, rsp_err_s);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if ({rsp_vld_s, req_rdy_s} !== 2'b01) begin
        errors++;
        $display("FAIL abort_quiet%0d vld/rdy got %b/%b exp 0/1", i, rsp_vld_s, req_rdy_s);
      end
    end
    run_search(8'h3B, 1'b0, -1, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 30; i++) begin
      run_search(int'($urandom_range(0, 255)), 1'($urandom % 2),
                 ($urandom % 4 == 0) ? int'($urandom_range(0, W - 1)) : -1,
                 int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_early();
    test_error();
    test_stall();
    test_reset_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
